// File: rtl/counter_watch.sv
// rtl/counter_watch.sv - transition monitor for an 8-bit loadable counter with event FIFO
//
// Samples C every clock, classifies each transition against the previous
// sample (HOLD / STEP / WRAP / JUMP, plus MATCH against MATCH_VAL) and queues
// WRAP, JUMP and MATCH records in a DEPTH-entry FIFO drained over EV_VALID /
// EV_READY. Also keeps a wrap counter, a saturating drop counter and a sticky
// overflow flag.
//
// Optional feature macro: COUNTER_WATCH_TIMESTAMP_EN
//   defined   : free-running 16-bit timestamp stored with each record, EV_TIME port
//   undefined : records are {type, value} only, no EV_TIME port
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   EN         in   sampling enable
//   CLR        in   synchronous clear of FIFO, counters, flags and history
//   C          in   [WIDTH] observed counter value
//   MATCH_VAL  in   [WIDTH] compare value for MATCH events
//   EV_VALID   out  record available at FIFO head
//   EV_READY   in   consumer accepts head record
//   EV_TYPE    out  [2] head type: 01 MATCH, 10 WRAP, 11 JUMP
//   EV_VALUE   out  [WIDTH] value of C when the record was captured
//   WRAP_CNT   out  [8] wraps seen, modulo 256
//   DROP_CNT   out  [8] records lost to a full FIFO, saturating
//   OVERFLOW   out  sticky: at least one record dropped
//   EV_TIME    out  [16] head record timestamp (timestamp build only)

module counter_watch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             CLR,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] MATCH_VAL,
    output logic             EV_VALID,
    input  logic             EV_READY,
    output logic [1:0]       EV_TYPE,
    output logic [WIDTH-1:0] EV_VALUE,
    output logic [7:0]       WRAP_CNT,
    output logic [7:0]       DROP_CNT,
    output logic             OVERFLOW
`ifdef COUNTER_WATCH_TIMESTAMP_EN
    ,
    output logic [15:0]      EV_TIME
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef COUNTER_WATCH_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int REC_W = 2 + WIDTH + TS_W;

    localparam logic [1:0] T_NONE  = 2'b00;
    localparam logic [1:0] T_MATCH = 2'b01;
    localparam logic [1:0] T_WRAP  = 2'b10;
    localparam logic [1:0] T_JUMP  = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [REC_W-1:0] head_q, head_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;
    logic [REC_W-1:0] mem_q [DEPTH];

`ifdef COUNTER_WATCH_TIMESTAMP_EN
    logic [15:0]      tstamp_q, tstamp_d;
`endif

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] prev_inc;
    logic             classify_en;
    logic             is_hold, is_step, is_wrap, is_jump, is_match;
    logic [1:0]       ev_type;
    logic             push;
    logic [REC_W-1:0] rec_new;

    assign prev_inc    = prev_q + WIDTH'(1);
    // CLR discards any event classified in its cycle.
    assign classify_en = EN && prev_vld_q && !CLR;

    assign is_hold  = (C == prev_q);
    assign is_step  = (C == prev_inc);
    assign is_wrap  = (prev_q == {WIDTH{1'b1}}) && (C == {WIDTH{1'b0}});
    assign is_jump  = !is_hold && !is_step;
    // Excluding HOLD makes a counter parked on MATCH_VAL report once.
    assign is_match = (C == MATCH_VAL) && !is_hold;

    // One record per cycle, JUMP > WRAP > MATCH.
    always_comb begin
        ev_type = T_NONE;
        if (classify_en) begin
            if (is_jump) begin
                ev_type = T_JUMP;
            end else if (is_wrap) begin
                ev_type = T_WRAP;
            end else if (is_match) begin
                ev_type = T_MATCH;
            end
        end
    end

    assign push = (ev_type != T_NONE);

`ifdef COUNTER_WATCH_TIMESTAMP_EN
    assign rec_new = {ev_type, C, tstamp_q};
`else
    assign rec_new = {ev_type, C};
`endif

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic empty, full, pop, push_acc, drop;

    assign empty = (wptr_q == rptr_q);
    // Pointers carry one extra bit: same slot, different lap means full.
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign pop      = !empty && EV_READY && !CLR;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push_acc = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (CLR) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_acc) begin
                wptr_d = wptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + (AW+1)'(1);
            end
        end
    end

    // The head register presents the record at the next read pointer. When
    // that slot is being written this cycle (push into an empty FIFO, or a
    // pop that drains the last entry while pushing), take the new record
    // directly. When the FIFO goes empty the last head is held.
    always_comb begin
        head_d = head_q;
        if (!CLR && (wptr_d != rptr_d)) begin
            if (push_acc && (rptr_d == wptr_q)) begin
                head_d = rec_new;
            end else begin
                head_d = mem_q[rptr_d[AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // History, counters, flags
    // ------------------------------------------------------------------
    always_comb begin
        prev_d     = EN ? C : prev_q;
        // Dropping validity while disabled prevents a false JUMP on re-enable.
        prev_vld_d = EN && !CLR;

        wrap_cnt_d = wrap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (CLR) begin
            wrap_cnt_d = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            // Counted on every wrap, whether or not the record is stored.
            if (classify_en && is_wrap) begin
                wrap_cnt_d = wrap_cnt_q + 8'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

`ifdef COUNTER_WATCH_TIMESTAMP_EN
    always_comb begin
        tstamp_d = CLR ? 16'd0 : tstamp_q + 16'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            head_q     <= '0;
            wrap_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            head_q     <= head_d;
            wrap_cnt_q <= wrap_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef COUNTER_WATCH_TIMESTAMP_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_d;
        end
    end
`endif

    // Storage array needs no reset: a slot is only read after it was written.
    always_ff @(posedge CLK) begin
        if (push_acc) begin
            mem_q[wptr_q[AW-1:0]] <= rec_new;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign EV_VALID = !empty;
    assign EV_TYPE  = head_q[REC_W-1 -: 2];
    assign EV_VALUE = head_q[REC_W-3 -: WIDTH];
    assign WRAP_CNT = wrap_cnt_q;
    assign DROP_CNT = drop_cnt_q;
    assign OVERFLOW = overflow_q;
`ifdef COUNTER_WATCH_TIMESTAMP_EN
    assign EV_TIME  = head_q[15:0];
`endif

endmodule

// File: tb/tb_counter_watch.sv
// tb/tb_counter_watch.sv - directed self-checking bench for counter_watch

module tb_counter_watch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] c = 8'd0;
    logic [7:0] match_val = 8'hFF;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [1:0] ev_type;
    logic [7:0] ev_value;
    logic [7:0] wrap_cnt;
    logic [7:0] drop_cnt;
    logic       overflow;
`ifdef COUNTER_WATCH_TIMESTAMP_EN
    logic [15:0] ev_time;
`endif

    int n_vec = 0;
    int n_bad = 0;

    counter_watch #(.WIDTH(8), .DEPTH(4)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .EN        (en),
        .CLR       (clr),
        .C         (c),
        .MATCH_VAL (match_val),
        .EV_VALID  (ev_valid),
        .EV_READY  (ev_ready),
        .EV_TYPE   (ev_type),
        .EV_VALUE  (ev_value),
        .WRAP_CNT  (wrap_cnt),
        .DROP_CNT  (drop_cnt),
        .OVERFLOW  (overflow)
`ifdef COUNTER_WATCH_TIMESTAMP_EN
        ,
        .EV_TIME   (ev_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] got_rec[$];
    logic [9:0] exp_run [2]  = '{{2'b01, 8'hFF}, {2'b10, 8'h00}};
    logic [7:0] seq_full [6] = '{8'd2, 8'd3, 8'd9, 8'd20, 8'd30, 8'd40};
    logic [9:0] exp_full [4] = '{{2'b11, 8'd2}, {2'b01, 8'd3}, {2'b11, 8'd9}, {2'b11, 8'd20}};
    logic [7:0] refill [4]   = '{8'd50, 8'd60, 8'd70, 8'd80};
    logic [7:0] exp_drain [4] = '{8'd60, 8'd70, 8'd80, 8'd90};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_type", 32'(ev_type), 32'd0);
        check("rst_value", 32'(ev_value), 32'd0);
        check("rst_wrap", 32'(wrap_cnt), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Free-running counter from 0 through one wrap, consumer always ready
        rst_n = 1'b1;
        en = 1'b1;
        ev_ready = 1'b1;
        tick();
        for (int i = 1; i <= 257; i++) begin
            c = 8'(i);
            tick();
            if (ev_valid) got_rec.push_back({ev_type, ev_value});
        end
        check("run_nrec", 32'(got_rec.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            check("run_rec", 32'((i < got_rec.size()) ? got_rec[i] : 10'h3FF), 32'(exp_run[i]));
        end
        check("run_wrapcnt", 32'(wrap_cnt), 32'd1);

        // Load of 42
        c = 8'd2; tick();
        c = 8'd3; tick();
        c = 8'd42;
        #1;
        check("load_pre_valid", 32'(ev_valid), 32'd0);
        tick();
        check("load_valid", 32'(ev_valid), 32'd1);
        check("load_type", 32'(ev_type), 32'd3);
        check("load_value", 32'(ev_value), 32'd42);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("load_hold", 32'(ev_valid), 32'd0);
        end

        // Fill FIFO with consumer stalled, two drops
        ev_ready = 1'b0;
        match_val = 8'd3;
        for (int i = 0; i < 4; i++) begin
            c = seq_full[i];
            tick();
        end
        check("full_valid", 32'(ev_valid), 32'd1);
        check("full_drop0", 32'(drop_cnt), 32'd0);
        for (int i = 4; i < 6; i++) begin
            c = seq_full[i];
            tick();
        end
        check("full_drop2", 32'(drop_cnt), 32'd2);
        check("full_ovf", 32'(overflow), 32'd1);
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_order", 32'({ev_type, ev_value}), 32'(exp_full[i]));
            tick();
        end
        check("full_empty", 32'(ev_valid), 32'd0);

        // Full FIFO with simultaneous pop and push
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = refill[i];
            tick();
        end
        check("pp_drop_pre", 32'(drop_cnt), 32'd2);
        ev_ready = 1'b1;
        c = 8'd90;
        tick();
        check("pp_drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", 32'({ev_valid, ev_value}), 32'({1'b1, exp_drain[i]}));
            tick();
        end
        check("pp_empty", 32'(ev_valid), 32'd0);

        // EN low for three cycles while counter advances
        en = 1'b0;
        c = 8'd91; tick();
        c = 8'd92; tick();
        c = 8'd93; tick();
        en = 1'b1;
        c = 8'd94; tick();
        check("reen_nojump", 32'(ev_valid), 32'd0);
        c = 8'd95; tick();
        check("reen_step", 32'(ev_valid), 32'd0);

        // CLR with records queued
        ev_ready = 1'b0;
        c = 8'd5; tick();
        c = 8'd100; tick();
        check("clr_pre_valid", 32'(ev_valid), 32'd1);
        check("clr_pre_wrap", 32'(wrap_cnt), 32'd1);
        clr = 1'b1;
        c = 8'd200;
        tick();
        clr = 1'b0;
        check("clr_valid", 32'(ev_valid), 32'd0);
        check("clr_wrap", 32'(wrap_cnt), 32'd0);
        check("clr_drop", 32'(drop_cnt), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);
        tick();
        check("clr_nohist", 32'(ev_valid), 32'd0);
        c = 8'd17; tick();
        c = 8'd30; tick();
        check("arst_pre_valid", 32'(ev_valid), 32'd1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ev_valid), 32'd0);
        check("arst_counts", 32'({wrap_cnt, drop_cnt, 7'd0, overflow}), 32'd0);
        check("arst_head", 32'({ev_type, ev_value}), 32'd0);
        #1;
        rst_n = 1'b1;
        c = 8'd77; tick();
        check("arst_first", 32'(ev_valid), 32'd0);
        c = 8'd120; tick();
        check("arst_jump", 32'({ev_valid, ev_type, ev_value}), 32'({1'b1, 2'b11, 8'd120}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
